// File: rtl/lp_bank_ram.sv
// lp_bank_ram: banked single-port synchronous RAM with per-lane write
// masking and autonomous per-bank retention sleep / timed wake.
//
// Ports:
//   CLK   in        clock, rising edge
//   RSTN  in        asynchronous active-low reset
//   A     in  AW    word address, upper log2(NB) bits select the bank
//   D     in  DW    write data
//   M     in  MW    write lane mask, bit i enables D[i*LW +: LW]
//   EN    in        access request
//   WR    in        1 = write, 0 = read
//   RDY   out       combinational: !EN, or addressed bank is active
//   Q     out DW    registered read data
//   SLP   out NB    bit b set while bank b sleeps
module lp_bank_ram #(
   parameter int AW       = 4,
   parameter int DW       = 8,
   parameter int MW       = 2,
   parameter int NB       = 2,
   parameter int IDLE_CYC = 8,
   parameter int WAKE_CYC = 2
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic [AW-1:0] A,
   input  logic [DW-1:0] D,
   input  logic [MW-1:0] M,
   input  logic          EN,
   input  logic          WR,
   output logic          RDY,
   output logic [DW-1:0] Q,
   output logic [NB-1:0] SLP
);

   localparam int LW    = DW / MW;
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW    = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
   localparam int KW    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      ST_ACT   = 2'd0,
      ST_SLEEP = 2'd1,
      ST_WAKE  = 2'd2
   } st_t;

   st_t           r_st   [NB];
   logic [IW-1:0] r_idle [NB];
   logic [KW-1:0] r_wk   [NB];
   logic [DW-1:0] r_mem  [DEPTH];
   logic [DW-1:0] r_q;

   logic [BW-1:0] w_bank;
   logic [NB-1:0] w_hit;
   logic          w_acc;

   // Bank select is a pure bit slice of A; a single bank has no select bits.
   generate
      if (NB > 1) begin : g_multi
         assign w_bank = A[AW-1 -: BW];
      end else begin : g_single
         assign w_bank = '0;
      end
   endgenerate

   assign RDY   = !EN || (r_st[w_bank] == ST_ACT);
   assign w_acc = EN && RDY && RSTN;
   assign Q     = r_q;

   // A request aimed at a bank, whether or not it can be accepted yet.
   always_comb begin
      w_hit = '0;
      for (int b = 0; b < NB; b++) begin
         w_hit[b] = EN && (w_bank == BW'(b));
      end
   end

   always_comb begin
      SLP = '0;
      for (int b = 0; b < NB; b++) begin
         SLP[b] = (r_st[b] == ST_SLEEP);
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int b = 0; b < NB; b++) begin
            r_st[b]   <= ST_ACT;
            r_idle[b] <= '0;
            r_wk[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < NB; b++) begin
            unique case (r_st[b])
               ST_ACT: begin
                  // In ACT a hit is always accepted, so it beats sleep entry.
                  if (w_hit[b]) begin
                     r_idle[b] <= '0;
                  end else if (IDLE_CYC > 0) begin
                     if (r_idle[b] == IW'(IDLE_CYC - 1)) begin
                        r_st[b]   <= ST_SLEEP;
                        r_idle[b] <= '0;
                     end else begin
                        r_idle[b] <= r_idle[b] + 1'b1;
                     end
                  end
               end
               ST_SLEEP: begin
                  if (w_hit[b]) begin
                     r_st[b] <= ST_WAKE;
                     r_wk[b] <= '0;
                  end
               end
               ST_WAKE: begin
                  // Runs to completion even if the request goes away.
                  if (r_wk[b] == KW'(WAKE_CYC - 1)) begin
                     r_st[b]   <= ST_ACT;
                     r_idle[b] <= '0;
                  end else begin
                     r_wk[b] <= r_wk[b] + 1'b1;
                  end
               end
               default: r_st[b] <= ST_ACT;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_q <= '0;
      end else if (w_acc && !WR) begin
         r_q <= r_mem[A];
      end
   end

   // Array is never reset so contents survive sleep, wake and reset.
   always_ff @(posedge CLK) begin
      if (w_acc && WR) begin
         for (int i = 0; i < MW; i++) begin
            if (M[i]) begin
               r_mem[A][i*LW +: LW] <= D[i*LW +: LW];
            end
         end
      end
   end

endmodule

// File: doc/lp_bank_ram.md
# lp_bank_ram

Banked, parametrised single-port synchronous RAM for the low-power library, with per-lane write masking and autonomous per-bank sleep. Each bank drops into a retention sleep state after a programmable number of idle cycles. On the next access it runs a timed wake sequence, and a ready handshake stalls the requester until the bank is usable. The block sits wherever the plain single-port RAM is used today but idle power matters.

## Interface
- AW, 4: total address width; upper log2(NB) bits select the bank.
- DW, 8: data width.
- MW, 2: write-mask lanes; DW must be a multiple of MW, lane width LW = DW/MW.
- NB, 2: bank count, power of two, 1 ≤ NB ≤ 2^(AW-1).
- IDLE_CYC, 8: idle cycles before a bank sleeps; 0 disables sleep.
- WAKE_CYC, 2: cycles spent in WAKE, ≥ 1.
- CLK  in  1  clock, all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- A  in  AW  word address.
- D  in  DW  write data.
- M  in  MW  write lane mask; bit i enables D[i*LW +: LW].
- EN  in  1  access request.
- WR  in  1  1 = write, 0 = read.
- RDY  out  1  combinational: !EN, or addressed bank in ACT.
- Q  out  DW  registered read data.
- SLP  out  NB  bit b = 1 when bank b is in SLEEP.

## Operation
- Access is accepted on a rising edge where EN & RDY = 1. Only the addressed bank sees the access.
- Write: for each lane i with M[i] = 1, mem[A] lane i takes D lane i. Other lanes are unchanged. Q holds.
- Write with M = 0: the array is unchanged, but the access still counts as bank activity.
- Read: Q ← mem[A]. Q holds its value at every edge without an accepted read.
- Memory contents are not reset. Contents are retained through SLEEP and WAKE.
- Per-bank FSM, states ACT, SLEEP, WAKE, with an idle counter and a wake counter:
  - ACT, access to this bank accepted: idle counter ← 0.
  - ACT, no access, IDLE_CYC > 0, counter == IDLE_CYC-1: → SLEEP.
  - ACT, no access, otherwise: counter + 1.
  - SLEEP, EN with A targeting this bank: → WAKE, wake counter ← 0. RDY = 0.
  - SLEEP, otherwise: stays in SLEEP. No array activity.
  - WAKE, wake counter == WAKE_CYC-1: → ACT, idle counter ← 0.
  - WAKE, otherwise: wake counter + 1.
  - WAKE completes even if EN drops or A moves to another bank.
- While RDY = 0 the requester holds EN, A, WR, D and M stable.
- Banks are independent. Other banks keep counting and sleeping while one bank wakes.

## Timing
- Reset (RSTN low, asynchronous): Q = 0; all banks in ACT; all counters = 0; SLP = 0; RDY = 1.
- Reset asserted mid-WAKE or mid-access aborts the operation. Banks return to ACT; array contents are undefined only for a write on the same edge.
- Read latency to an ACT bank: 1 cycle. Accept at edge k, Q valid after edge k.
- Access to a sleeping bank, request first presented in cycle 0:
  - RDY = 0 in cycles 0 through WAKE_CYC.
  - RDY = 1 in cycle WAKE_CYC+1; the access is accepted at that edge.
  - With the default WAKE_CYC = 2, read data is on Q in cycle 4.
- Sleep entry: a bank idle for IDLE_CYC consecutive cycles after its last accepted access shows SLP = 1 from the next cycle.
- If an access arrives in the same cycle the counter reaches IDLE_CYC-1, the access wins: the bank stays in ACT and the counter ← 0.
- Address wrap: bank and offset are pure bit slices of A, with no carry between them.

## Test plan
- Reset, then write 0xA5 with M=2'b11 to A=3 and read A=3 → Q = 0xA5 one cycle after the read is accepted; RDY stays 1 throughout.
- Masked write: mem[5] = 0xFF, write D=0x00 with M=2'b01 → a read of A=5 returns 0xF0.
- Leave bank 0 idle for 8 cycles → SLP[0] = 1 at cycle 9. Read bank 0 at cycle 0 → RDY low for cycles 0–2, high in cycle 3, data on Q in cycle 4. Contents are retained.
- Access bank 0 on exactly the 8th idle cycle → SLP[0] stays 0 and the idle counter restarts.
- Bank 1 waking while bank 0 is active → bank 0 reads proceed with RDY = 1 and latency 1, unaffected by bank 1.
- Assert RSTN low mid-WAKE → Q = 0, SLP = 0 and RDY = 1 immediately. A following read returns the pre-reset contents, showing retention.
